// File: rtl/muldiv_unit_if.sv
// Request/result bundle for muldiv_unit: the master issues operations,
// the slave (the unit) returns status and the HI/LO results.
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic             flush;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, flush, dataA, dataB,
    input  busy, done, dbz, hi, lo
  );

  modport slave (
    input  start, op, flush, dataA, dataB,
    output busy, done, dbz, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit (MULTU/DIVU) with HI/LO result
// registers: one result bit per cycle, abortable by flush.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [CW-1:0]        cnt_r;
  logic [WIDTH-1:0]     opa_r;
  logic [WIDTH-1:0]     opb_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     rem_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;
  logic                 dbz_r;
  logic                 busy_r;
  logic                 done_r;

  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_shift_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     div_diff_s;
  logic [WIDTH-1:0]     rem_next_s;
  logic [WIDTH-1:0]     quo_next_s;
  logic                 last_s;
  logic                 div_zero_s;
  logic                 accept_s;

  assign last_s     = (cnt_r == LAST);
  assign div_zero_s = (opb_r == {WIDTH{1'b0}});
  assign accept_s   = bus.start && !bus.flush;

  // One shift-add or restoring-divide step; acc_r holds {partial product, multiplier}
  // for MULTU and the shifting dividend/quotient in its low half for DIVU.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                + (acc_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_shift_s = {rem_r, acc_r[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, opb_r});
    div_diff_s  = div_shift_s[WIDTH-1:0] - opb_r;
    rem_next_s  = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
    quo_next_s  = {acc_r[WIDTH-2:0], div_ge_s};
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = bus.op ? DIV : MUL;
        end else begin
          state_next_s = IDLE;
        end
      end
      MUL: begin
        if (bus.flush) begin
          state_next_s = IDLE;
        end else if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = MUL;
        end
      end
      DIV: begin
        if (bus.flush) begin
          state_next_s = IDLE;
        end else if (div_zero_s || last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DIV;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == MUL) || (state_next_s == DIV);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Operand capture, iteration and HI/LO commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
      opa_r <= {WIDTH{1'b0}};
      opb_r <= {WIDTH{1'b0}};
      acc_r <= {(2*WIDTH){1'b0}};
      rem_r <= {WIDTH{1'b0}};
      hi_r  <= {WIDTH{1'b0}};
      lo_r  <= {WIDTH{1'b0}};
      dbz_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            opa_r <= bus.dataA;
            opb_r <= bus.dataB;
            acc_r <= {{WIDTH{1'b0}}, (bus.op ? bus.dataA : bus.dataB)};
            rem_r <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
          end
        end
        MUL: begin
          if (!bus.flush) begin
            acc_r <= mul_next_s;
            cnt_r <= cnt_r + CW'(1);
            if (last_s) begin
              hi_r  <= mul_next_s[2*WIDTH-1:WIDTH];
              lo_r  <= mul_next_s[WIDTH-1:0];
              dbz_r <= 1'b0;
            end
          end
        end
        DIV: begin
          // A zero divisor short-circuits the iteration with the MIPS-style result
          if (!bus.flush) begin
            if (div_zero_s) begin
              hi_r  <= opa_r;
              lo_r  <= {WIDTH{1'b1}};
              dbz_r <= 1'b1;
            end else begin
              acc_r <= {acc_r[2*WIDTH-1:WIDTH], quo_next_s};
              rem_r <= rem_next_s;
              cnt_r <= cnt_r + CW'(1);
              if (last_s) begin
                hi_r  <= rem_next_s;
                lo_r  <= quo_next_s;
                dbz_r <= 1'b0;
              end
            end
          end
        end
        DONE:    cnt_r <= cnt_r;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.dbz  = dbz_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width and the HI/LO width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 1 bit: operation select; 0 = MULTU, 1 = DIVU (both unsigned).
REQ-006 The block SHALL have port flush, input, 1 bit: pipeline flush, a synchronous abort.
REQ-007 The block SHALL have port dataA, input, WIDTH bits: multiplicand or dividend.
REQ-008 The block SHALL have port dataB, input, WIDTH bits: multiplier or divisor.
REQ-009 The block SHALL have port busy, output, 1 bit: high in MUL or DIV; the pipeline stalls on it.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse, high in DONE.
REQ-011 The block SHALL have port dbz, output, 1 bit: the last completed DIVU had divisor 0.
REQ-012 The block SHALL have port hi, output, WIDTH bits: the HI register.
REQ-013 The block SHALL have port lo, output, WIDTH bits: the LO register.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, DIV and DONE, with IDLE as the reset state.
REQ-015 In IDLE, start=1 with flush=0 SHALL latch dataA, dataB and op, clear the iteration counter and go to MUL (op=0) or DIV (op=1).
REQ-016 Operand changes after acceptance SHALL be ignored, and start SHALL be ignored in MUL, DIV and DONE.
REQ-017 MUL SHALL run an unsigned shift-add over a 2*WIDTH-bit accumulator, one multiplier bit per cycle, for exactly WIDTH cycles.
REQ-018 DIV SHALL run an unsigned restoring division, one quotient bit per cycle, for exactly WIDTH cycles.
REQ-019 On the cycle of the last iteration, the FSM SHALL go to DONE and load hi/lo in the same edge.
- MULTU: hi = product[2W-1:W], lo = product[W-1:0].
- DIVU: hi = remainder, lo = quotient.
REQ-020 Latency: an operation accepted at edge N SHALL assert done in cycle N+WIDTH+1 (33 cycles for WIDTH=32), and busy SHALL be high in cycles N+1 through N+WIDTH.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE unconditionally; a new start can be accepted at the edge leaving IDLE only.
REQ-022 A DIVU with divisor 0 SHALL skip iteration: go from DIV to DONE after one cycle with hi = dividend, lo = all ones, dbz = 1.
REQ-023 Any completed operation without divide-by-zero SHALL clear dbz.
REQ-024 flush=1 in MUL or DIV SHALL return the FSM to IDLE at the next edge, leave hi/lo/dbz unchanged and generate no done pulse.
REQ-025 flush=1 in DONE SHALL not cancel the already-committed hi/lo.
REQ-026 flush=1 together with start=1 in IDLE SHALL accept nothing (flush wins).
REQ-027 The datapath SHALL have no overflow: the multiplier accumulator is 2*WIDTH bits, and the divider partial remainder is WIDTH+1 bits.
REQ-028 hi and lo SHALL change only on entry to DONE or on reset.

Reset
REQ-029 rst=1 SHALL immediately and asynchronously force state = IDLE, busy = 0, done = 0, dbz = 0, hi = 0, lo = 0, and counter/accumulators to 0.
REQ-030 Reset asserted mid-operation SHALL discard the operation with no done pulse, and after rst falls the block SHALL accept start on the first edge.

Verification
REQ-031 The bench SHALL cover MULTU 7 x 6: done 33 cycles after acceptance, hi = 0x00000000, lo = 0x0000002A, busy high for 32 cycles.
REQ-032 The bench SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF: hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-033 The bench SHALL cover DIVU 100 / 7: hi = 2, lo = 14, dbz = 0, done at cycle N+33.
REQ-034 The bench SHALL cover DIVU 5 / 0: done at cycle N+2, hi = 5, lo = 0xFFFFFFFF, dbz = 1; a following DIVU 9 / 3 SHALL give lo = 3, hi = 0, dbz = 0.
REQ-035 The bench SHALL cover flush 10 cycles into a MULTU after a completed 7 x 6: busy = 0 next cycle, no done pulse, hi/lo stay 0 / 0x2A; start held high during busy SHALL not restart the operation.
REQ-036 The bench SHALL cover rst pulsed asynchronously (between clock edges) 15 cycles into a DIVU: busy, done, hi and lo read 0 before the next clock edge, and a new MULTU 3 x 4 issued after rst falls gives lo = 12.
